shift_sequencer: RTL and testbench

//  Multi-cycle variable shifter for the ALU shift instructions (sll/srl/sra, 0..31 bits).

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_shift_step.sv | 31 +++
 rtl/shift_sequencer.sv | 93 +++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: FSM states and
// shift direction encodings.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_shift_step.sv
// One combinational iteration of the shifter: shift by 1 or 2, left with
// zero fill, or right with zero or sign fill.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             dir,
    input  logic             arith,
    input  logic             by2,
    output logic [WIDTH-1:0] next_acc
);

    logic w_fill;

    // Sign is taken from the current acc each step; sign fill never changes the MSB.
    assign w_fill = (dir == DIR_RIGHT) && arith && acc[WIDTH-1];

    always_comb begin
        next_acc = acc;
        if (dir == DIR_LEFT) begin
            if (by2) next_acc = {acc[WIDTH-3:0], 2'b00};
            else     next_acc = {acc[WIDTH-2:0], 1'b0};
        end else begin
            if (by2) next_acc = {{2{w_fill}}, acc[WIDTH-1:2]};
            else     next_acc = {w_fill, acc[WIDTH-1:1]};
        end
    end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: consumes the shift amount two bits per clock
// through shift_step, with a start/busy/done handshake to the control unit.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_rem;
    logic             r_dir;
    logic             r_arith;
    logic             r_busy;
    logic             r_done;

    logic             w_by2;
    logic [WIDTH-1:0] w_next;

    assign w_by2 = (r_rem >= SHW'(2));

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (r_acc),
        .dir      (r_dir),
        .arith    (r_arith),
        .by2      (w_by2),
        .next_acc (w_next)
    );

    // busy/done are registered alongside the state so they decode the state it is entering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc   <= a;
                        r_rem   <= shamt;
                        r_dir   <= dir;
                        r_arith <= arith;
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_rem != '0) begin
                        r_acc <= w_next;
                        r_rem <= w_by2 ? (r_rem - SHW'(2)) : '0;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_acc;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a cycle-level reference model checks every cycle,
// plus directed operations with literal results and latencies.
module tb_shift_sequencer;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [SW-1:0] shamt;
    logic          dir;
    logic          arith;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shift_sequencer #(
        .WIDTH (W),
        .SHW   (SW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .dir    (dir),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int sh,
                                               input logic d, input logic ar);
        logic signed [W-1:0] s;
        s = v;
        if (!d)      return v << sh;
        else if (ar) return W'(s >>> sh);
        else         return v >> sh;
    endfunction

    // Reference model: an accepted op is busy until done_c, done only at done_c,
    // and result must equal the expected value whenever it is not in flight.
    bit           m_known  = 1'b0;
    bit           m_active = 1'b0;
    bit           m_idle_now;
    int           m_done_c = 0;
    logic [W-1:0] m_res    = '0;

    always @(negedge clk) begin
        if (m_known) begin
            chk("busy", W'(busy), W'(m_active));
            chk("done", W'(done), W'(m_active && (cyc == m_done_c)));
            if (!m_active || cyc == m_done_c)
                chk("result", result, m_res);
        end
        m_idle_now = !m_active;
        if (m_active && cyc == m_done_c) m_active = 1'b0;
        if (rst) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_res    = '0;
        end else if (m_known && m_idle_now && start) begin
            m_active = 1'b1;
            m_done_c = cyc + (int'(shamt) + 1) / 2 + 2;
            m_res    = ref_shift(a, int'(shamt), dir, arith);
        end
    end

    task automatic wait_done(input string name, input int t, input int exp_lat,
                             input logic [W-1:0] exp_res);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            chk({name, " latency"}, W'(cyc - t), W'(exp_lat));
            chk({name, " value"}, result, exp_res);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: no done within 40 cycles, expected %h", name, exp_res);
        end
    endtask

    task automatic issue(input logic [W-1:0] va, input int sh, input logic d,
                         input logic ar, output int t);
        @(posedge clk); #1;
        start = 1'b1;
        a     = va;
        shamt = SW'(sh);
        dir   = d;
        arith = ar;
        t     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        shamt = SW'($urandom);
        dir   = 1'($urandom);
        arith = 1'($urandom);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] va, input int sh,
                          input logic d, input logic ar, input int exp_lat,
                          input logic [W-1:0] exp_res);
        int t;
        issue(va, sh, d, ar, t);
        wait_done(name, t, exp_lat, exp_res);
    endtask

    task automatic count_dones(input string name, input int ncyc);
        int cnt;
        cnt = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk(name, W'(cnt), '0);
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; a = '0; shamt = '0; dir = 1'b0; arith = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", W'(busy), '0);
        chk("reset done", W'(done), '0);
        chk("reset result", result, '0);

        run_op("sra3",        32'h80000001, 3,  1'b1, 1'b1, 4,  32'hF0000000);
        run_op("sll31",       32'h00000001, 31, 1'b0, 1'b0, 18, 32'h80000000);
        run_op("srl31",       32'h80000000, 31, 1'b1, 1'b0, 18, 32'h00000001);
        run_op("sra31",       32'h80000000, 31, 1'b1, 1'b1, 18, 32'hFFFFFFFF);
        run_op("shamt0",      32'h12345678, 0,  1'b0, 1'b0, 2,  32'h12345678);
        run_op("sll4",        32'h12345678, 4,  1'b0, 1'b0, 4,  32'h23456780);
        run_op("sll1 arith",  32'hC0000001, 1,  1'b0, 1'b1, 3,  32'h80000002);
        run_op("sra2 pos",    32'h7FFFFFFC, 2,  1'b1, 1'b1, 3,  32'h1FFFFFFF);

        // start pulses with a fresh operand while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1; a = 32'h80000001; shamt = 5'd3; dir = 1'b1; arith = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        a = 32'hDEADBEEF; shamt = 5'd1; dir = 1'b0; arith = 1'b0;
        @(posedge clk); #1;
        a = 32'h0000FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy start", t, 4, 32'hF0000000);
        count_dones("no second done", 25);

        // synchronous reset in the middle of a long op
        issue(32'hA5A5A5A5, 20, 1'b0, 1'b0, t);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", W'(busy), '0);
        chk("abort done", W'(done), '0);
        chk("abort result", result, '0);
        count_dones("no done after abort", 20);
        run_op("after abort", 32'hA5A5A5A5, 20, 1'b1, 1'b1, 12, 32'hFFFFFA5A);

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            start = ($urandom % 3) == 0;
            a     = $urandom;
            shamt = SW'($urandom);
            dir   = 1'($urandom);
            arith = 1'($urandom);
            rst   = ($urandom % 97) == 0;
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_sequencer
